// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and helpers
// used by both the RX and TX blocks.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received UART entries; a pop on a full
// FIFO frees the slot for a push in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [clog2(DEPTH):0]    count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote, framing FSM,
// sticky error flags and a show-ahead receive FIFO.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          sample_tick,
    input  logic                          RXD,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_ferr,
    output logic                          rx_perr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          clr_err,
    output logic                          busy,
    output logic                          irq
);

    localparam int unsigned TW   = clog2(OVS);
    localparam int unsigned BW   = clog2(DATA_BITS);
    localparam int unsigned HALF = OVS / 2;
    localparam int unsigned EW   = DATA_BITS + 2;

    logic                 sync1_q, sync2_q;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 vote_q, vote_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 par_bit_q, par_bit_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;

    logic                 line, tick_last, ferr_now, push, drop, brk_evt;
    logic                 par_mode;
    logic                 fifo_full, fifo_empty;
    logic [EW-1:0]        push_entry, head;

    assign line      = sync2_q;
    assign tick_last = (tick_cnt_q == TW'(OVS - 1));
    assign ferr_now  = ferr_q | ~vote_q;
    assign par_mode  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        vote_d     = vote_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_bit_d  = par_bit_q;
        push       = 1'b0;
        if (sample_tick) begin
            tick_cnt_d = tick_last ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == TW'(HALF - 1)) samp_d[0] = line;
            if (tick_cnt_q == TW'(HALF))     samp_d[1] = line;
            if (tick_cnt_q == TW'(HALF + 1)) vote_d = maj3(samp_q[0], samp_q[1], line);
            case (state_q)
                // The detecting tick is tick 0 of the start bit, so back-to-back
                // frames stay aligned without an extra idle tick.
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    if (!line) begin
                        state_d    = ST_START;
                        tick_cnt_d = TW'(1);
                    end
                end
                ST_START: begin
                    if (tick_last) begin
                        state_d   = vote_q ? ST_IDLE : ST_DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                        par_bit_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        shift_d = {vote_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_last) begin
                        par_bit_d = vote_q;
                        perr_d    = vote_q != ((^shift_q) ^ par_mode);
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_last) begin
                        ferr_d = ferr_now;
                        if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign push_entry = {perr_q, ferr_now, shift_q};
    assign brk_evt    = push && (shift_q == '0) && ferr_now && ((PARITY_EN == 0) || !par_bit_q);
    assign drop       = push && fifo_full && !rx_ready;

    always_comb begin
        overrun_d = clr_err ? 1'b0 : overrun_q;
        break_d   = clr_err ? 1'b0 : break_q;
        if (drop)    overrun_d = 1'b1;
        if (brk_evt) break_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '1;
            vote_q     <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            sync1_q    <= RXD;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            vote_q     <= vote_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_bit_q  <= par_bit_d;
            overrun_q  <= overrun_d;
            break_q    <= break_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (RST),
        .push_i (push),
        .pop_i  (rx_ready),
        .wdata_i(push_entry),
        .rdata_o(head),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Head is gated while empty so unwritten storage never reaches the outputs.
    assign rx_valid  = !fifo_empty;
    assign rx_data   = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_ferr   = rx_valid & head[DATA_BITS];
    assign rx_perr   = rx_valid & head[DATA_BITS+1];
    assign overrun   = overrun_q;
    assign break_det = break_q;
    assign busy      = (state_q != ST_IDLE);
    assign irq       = rx_valid | overrun_q | break_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: an 8N1 instance and an 8E1 instance,
// directed frames with hand-computed entries queued for the pop monitors.
module tb_uart_rx_ovs;

    localparam int OVS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RST, sample_tick, clr_err;
    logic       rxd0, rxd1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       ferr0, perr0, valid0, ovr0, brk0, busy0, irq0;
    logic       ferr1, perr1, valid1, ovr1, brk1, busy1, irq1;
    logic [3:0] cnt0, cnt1;

    uart_rx_ovs #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                  .OVS(OVS), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .RST(RST), .sample_tick(sample_tick), .RXD(rxd0),
        .rx_data(d0), .rx_ferr(ferr0), .rx_perr(perr0), .rx_valid(valid0),
        .rx_ready(rdy0), .fifo_count(cnt0), .overrun(ovr0), .break_det(brk0),
        .clr_err(clr_err), .busy(busy0), .irq(irq0));

    uart_rx_ovs #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                  .OVS(OVS), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .RST(RST), .sample_tick(sample_tick), .RXD(rxd1),
        .rx_data(d1), .rx_ferr(ferr1), .rx_perr(perr1), .rx_valid(valid1),
        .rx_ready(rdy1), .fifo_count(cnt1), .overrun(ovr1), .break_det(brk1),
        .clr_err(clr_err), .busy(busy1), .irq(irq1));

    int checks = 0;
    int failures = 0;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];
    logic [9:0] e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // sample_tick: one clock high every 4 clocks
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    // Monitors: compare the FIFO head on every accepted pop
    always @(negedge clk) begin
        if (!RST && valid0 && rdy0) begin
            if (exp0.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut0_unexpected: got 0x%0h want none", {perr0, ferr0, d0});
            end else begin
                e0 = exp0.pop_front();
                check("dut0_entry", {perr0, ferr0, d0}, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (!RST && valid1 && rdy1) begin
            if (exp1.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut1_unexpected: got 0x%0h want none", {perr1, ferr1, d1});
            end else begin
                e1 = exp1.pop_front();
                check("dut1_entry", {perr1, ferr1, d1}, e1);
            end
        end
    end

    task automatic next_tick();
        do @(posedge clk); while (!sample_tick);
        #2;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rxd0 = v;
        else            rxd1 = v;
    endtask

    task automatic send_bit(input int which, input logic b, input bit glitch);
        drive(which, b);
        if (glitch) begin
            repeat (8) next_tick();
            drive(which, ~b);
            next_tick();
            drive(which, b);
            repeat (7) next_tick();
        end else begin
            repeat (OVS) next_tick();
        end
    endtask

    // mode 0: plain; 1: check rx_valid rises one clock after the stop tick;
    // 2: assert rx_ready exactly in the push cycle
    task automatic send(input int which, input logic [7:0] data, input bit has_par,
                        input logic par, input logic stop, input bit glitch, input int mode);
        next_tick();
        send_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, data[i], glitch);
        if (has_par) send_bit(which, par, 1'b0);
        drive(which, stop);
        if (mode == 0) begin
            repeat (OVS) next_tick();
        end else begin
            repeat (OVS - 1) next_tick();
            @(posedge sample_tick);
            #1;
            if (mode == 1) check("lat_before", valid0, 1'b0);
            else           rdy0 = 1'b1;
            @(posedge clk);
            #1;
            if (mode == 1) check("lat_after", valid0, 1'b1);
            else           rdy0 = 1'b0;
        end
        drive(which, 1'b1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        RST = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; clr_err = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", valid0, 1'b0);
        check("rst_count", cnt0, 4'd0);
        check("rst_flags", {ovr0, brk0, busy0, irq0}, 4'b0000);
        check("rst_data", d0, 8'h00);
        check("rst_dut1", {valid1, ovr1, brk1, busy1, irq1}, 5'b00000);
        RST = 1'b0;
        repeat (3) next_tick();

        // Basic 8N1 frame and push latency
        exp0.push_back({2'b00, 8'hA5});
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // False start: 4 ticks low
        next_tick();
        drive(0, 1'b0);
        repeat (4) next_tick();
        drive(0, 1'b1);
        check("fs_busy", busy0, 1'b1);
        repeat (OVS - 4) next_tick();
        check("fs_idle", busy0, 1'b0);
        check("fs_flags", {cnt0, ovr0, brk0}, 6'd0);

        // Framing error, then break
        exp0.push_back({2'b01, 8'h3C});
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("ferr_nobrk", brk0, 1'b0);
        exp0.push_back({2'b01, 8'h00});
        send(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("brk_set", brk0, 1'b1);
        check("brk_irq", irq0, 1'b1);
        pulse_clr();
        check("brk_clr", brk0, 1'b0);

        // Even parity on 0x07 expects parity bit 1
        exp1.push_back({2'b10, 8'h07});
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        exp1.push_back({2'b00, 8'h07});
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        exp1.push_back({2'b01, 8'h00});
        send(1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("brk_par", brk1, 1'b1);
        pulse_clr();
        check("brk_par_clr", brk1, 1'b0);
        exp1.push_back({2'b11, 8'h00});
        send(1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("brk_par1", brk1, 1'b0);

        // Fill the FIFO, overflow, then push+pop while full
        rdy0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp0.push_back({2'b00, 8'h10 + 8'(i)});
            send(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 0);
            if (i == 7) check("full_no_ovr", {cnt0, ovr0}, {4'd8, 1'b0});
        end
        check("ovf_count", cnt0, 4'd8);
        check("ovf_flag", ovr0, 1'b1);
        check("ovf_irq", irq0, 1'b1);
        pulse_clr();
        check("ovf_clr", ovr0, 1'b0);
        exp0.push_back({2'b00, 8'h19});
        send(0, 8'h19, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        check("full_pushpop_cnt", cnt0, 4'd8);
        check("full_pushpop_ovr", ovr0, 1'b0);
        rdy0 = 1'b1;
        for (int i = 0; i < 100 && cnt0 != 4'd0; i++) @(posedge clk);
        #1 check("drain_count", cnt0, 4'd0);

        // Reset in the middle of data bits, then a glitched clean frame
        next_tick();
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        drive(0, 1'b1);
        check("mid_busy", busy0, 1'b1);
        @(posedge clk); #1 RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst", {busy0, valid0, cnt0}, 6'd0);
        RST = 1'b0;
        repeat (OVS) next_tick();
        exp0.push_back({2'b00, 8'h5A});
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 0);

        for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0); i++) @(posedge clk);
        #1;
        check("sb0_empty", exp0.size(), 0);
        check("sb1_empty", exp1.size(), 0);
        check("end_valid", {valid0, valid1}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
